// File: rtl/bird_physics_pkg.sv
// bird_physics_pkg: shared screen/bird constants and the bird motion states.
package bird_physics_pkg;
    localparam int SCREEN_HEIGHT     = 480;
    localparam int BIRD_SIZE         = 40;
    localparam int BIRD_START_HEIGHT = 240;
    typedef enum logic [1:0] {IDLE, FLY, DEAD} bird_state_t;
endpackage

// File: rtl/bird_physics_flap_edge.sv
// flap_edge: rising-edge detector for the synchronized flap button.
module flap_edge (
    input  logic clk,
    input  logic reset,
    input  logic flap,
    output logic rise
);
    logic flap_q;
    always_ff @(posedge clk)
        flap_q <= reset ? 1'b0 : flap;
    assign rise = flap & ~flap_q;
endmodule

// File: rtl/bird_physics.sv
// bird_physics: per-frame vertical motion of the bird (flap, gravity, ceiling/floor clamps, death).
module bird_physics
    import bird_physics_pkg::*;
#(
    parameter int FLAP_VELOCITY = 8,
    parameter int GRAVITY       = 1,
    parameter int MAX_FALL      = 10,
    parameter int START_HEIGHT  = BIRD_START_HEIGHT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       flap,
    input  logic       hit,
    input  logic       restart,
    output logic [8:0] bird_height,
    output logic [5:0] velocity,
    output logic       alive,
    output logic       grounded
);
    localparam logic signed [10:0] FLAP_S  = 11'(FLAP_VELOCITY);
    localparam logic signed [10:0] GRAV_S  = 11'(GRAVITY);
    localparam logic signed [10:0] FALL_S  = -11'(MAX_FALL);
    localparam logic signed [10:0] TOP_S   = 11'(SCREEN_HEIGHT);
    localparam logic signed [10:0] FLOOR_S = 11'(BIRD_SIZE);

    bird_state_t       state_q, state_d;
    logic [8:0]        height_q, height_d;
    logic signed [5:0] vel_q, vel_d;
    logic              pending_q, pending_d;
    logic              grounded_q, grounded_d;
    logic              rise, flap_eff, at_top, at_floor;
    logic signed [10:0] v_ext, v_fall, v_new, h_sum;
    logic [8:0]        h_clamp;
    logic signed [5:0] v_clamp;

    flap_edge u_flap_edge (.clk(clk), .reset(reset), .flap(flap), .rise(rise));

    // A hit in the same cycle discards any flap, so only gravity applies.
    assign flap_eff = (state_q == FLY) && (pending_q || rise) && !hit;

    always_comb begin
        v_ext    = vel_q;
        v_fall   = v_ext - GRAV_S;
        v_fall   = (v_fall < FALL_S) ? FALL_S : v_fall;
        v_new    = flap_eff ? FLAP_S : v_fall;
        h_sum    = $signed({2'b00, height_q}) + v_new;
        at_top   = h_sum >= TOP_S;
        at_floor = h_sum <= FLOOR_S;
        h_clamp  = at_top ? 9'(SCREEN_HEIGHT) : at_floor ? 9'(BIRD_SIZE) : h_sum[8:0];
        v_clamp  = (at_top || at_floor) ? 6'sd0 : v_new[5:0];
    end

    always_comb begin
        state_d    = state_q;
        height_d   = height_q;
        vel_d      = vel_q;
        pending_d  = pending_q;
        grounded_d = grounded_q;
        unique case (state_q)
            IDLE: begin
                height_d   = 9'(START_HEIGHT);
                vel_d      = '0;
                grounded_d = 1'b0;
                pending_d  = rise;
                state_d    = rise ? FLY : IDLE;
            end
            FLY: begin
                pending_d = frame_tick ? 1'b0 : (pending_q || rise);
                height_d  = frame_tick ? h_clamp : height_q;
                vel_d     = frame_tick ? v_clamp : vel_q;
                if (hit || (frame_tick && at_floor)) begin
                    state_d    = DEAD;
                    pending_d  = 1'b0;
                    grounded_d = frame_tick && at_floor;
                end
            end
            DEAD: begin
                pending_d = 1'b0;
                if (restart && grounded_q) begin
                    state_d    = IDLE;
                    height_d   = 9'(START_HEIGHT);
                    vel_d      = '0;
                    grounded_d = 1'b0;
                end else if (frame_tick) begin
                    height_d   = h_clamp;
                    vel_d      = v_clamp;
                    grounded_d = grounded_q || at_floor;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            height_q   <= 9'(START_HEIGHT);
            vel_q      <= '0;
            pending_q  <= 1'b0;
            grounded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            height_q   <= height_d;
            vel_q      <= vel_d;
            pending_q  <= pending_d;
            grounded_q <= grounded_d;
        end
    end

    assign bird_height = height_q;
    assign velocity    = vel_q;
    assign alive       = (state_q == FLY);
    assign grounded    = grounded_q;
endmodule

// File: tb/tb_bird_physics.sv
// tb_bird_physics: directed + randomized stimulus against a frame-level model, scoreboard-checked each cycle.
module tb_bird_physics;
    logic clk = 0, reset = 0, frame_tick = 0, flap = 0, hit = 0, restart = 0;
    logic [8:0] bird_height;
    logic [5:0] velocity;
    logic alive, grounded;

    bird_physics dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .flap(flap), .hit(hit),
        .restart(restart), .bird_height(bird_height), .velocity(velocity),
        .alive(alive), .grounded(grounded)
    );

    always #5 clk = ~clk;

    typedef struct {int h; int v; bit alive; bit gnd;} exp_t;
    exp_t sb[$];
    int errors = 0, checks = 0;

    // model: 0 = waiting to start, 1 = flying, 2 = dead
    int m_mode = 0, m_h = 240, m_v = 0;
    bit m_pend = 0, m_prev = 0, m_gnd = 0;

    function automatic void physics(input bit do_flap, inout int h, inout int v, output bit floor_hit);
        v = do_flap ? 8 : ((v - 1 < -10) ? -10 : v - 1);
        h = h + v;
        floor_hit = 0;
        if (h >= 480) begin h = 480; v = 0; end
        if (h <= 40) begin h = 40; v = 0; floor_hit = 1; end
    endfunction

    task automatic model_step(input bit rs, input bit tk, input bit fl, input bit ht, input bit rr);
        bit edge_now, fh;
        edge_now = fl && !m_prev;
        m_prev = rs ? 0 : fl;
        if (rs) begin
            m_mode = 0; m_h = 240; m_v = 0; m_pend = 0; m_gnd = 0;
        end else if (m_mode == 0) begin
            if (edge_now) begin m_mode = 1; m_pend = 1; end
        end else if (m_mode == 1) begin
            fh = 0;
            if (tk) physics((m_pend || edge_now) && !ht, m_h, m_v, fh);
            m_pend = tk ? 0 : (m_pend || edge_now);
            if (ht || fh) begin m_mode = 2; m_pend = 0; m_gnd = fh; end
        end else begin
            m_pend = 0;
            if (rr && m_gnd) begin
                m_mode = 0; m_h = 240; m_v = 0; m_gnd = 0;
            end else if (tk) begin
                physics(0, m_h, m_v, fh);
                if (fh) m_gnd = 1;
            end
        end
    endtask

    task automatic cyc(input bit rs, input bit tk, input bit fl, input bit ht, input bit rr);
        @(negedge clk);
        reset = rs; frame_tick = tk; flap = fl; hit = ht; restart = rr;
        model_step(rs, tk, fl, ht, rr);
        sb.push_back('{m_h, m_v, m_mode == 1, m_gnd});
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("bird_height", int'(bird_height), e.h);
            check("velocity", int'($signed(velocity)), e.v);
            check("alive", int'(alive), int'(e.alive));
            check("grounded", int'(grounded), int'(e.gnd));
        end
    end

    initial begin
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0); end
        cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        // flap every frame up to the ceiling, multiple edges per frame
        for (int i = 0; i < 35; i++) begin
            cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 1, 0, 0, 0);
        end
        // free fall to the floor, then restart while grounded
        for (int i = 0; i < 60; i++) begin cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 1); end
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);
        // hit + tick + flap together while climbing, then ignored flaps/restart
        cyc(0, 0, 1, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0); cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin cyc(0, 0, 1, 0, 1); cyc(0, 1, 0, 0, 0); end
        cyc(0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        for (int seg = 0; seg < 20; seg++) begin
            int fp, hp;
            fp = $urandom_range(0, 50);
            hp = $urandom_range(0, 3);
            for (int i = 0; i < 200; i++) begin
                cyc($urandom_range(0, 999) == 0, (i % 4) == 3, $urandom_range(0, 99) < fp,
                    $urandom_range(0, 99) < hp, $urandom_range(0, 9) == 0);
            end
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
